// File: rtl/conv_pkg.sv
// Shared widths, pixel/accumulator types and Sobel-Y coefficients for the 3x3 gradient filter.
package conv_pkg;

  localparam int DATA_W = 12;
  localparam int ACC_W  = 16;

  typedef logic signed [DATA_W-1:0] pixel_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Outer/centre weights of a kernel row; the middle kernel row is all zero.
  localparam acc_t K_OUTER  = 16'sd1;
  localparam acc_t K_CENTER = 16'sd2;

  // Weighted (1,2,1) sum of one kernel row, sign-extended to the accumulator width.
  function automatic acc_t row_sum(input pixel_t left, input pixel_t mid, input pixel_t right);
    return (K_OUTER * acc_t'(left)) + (K_CENTER * acc_t'(mid)) + (K_OUTER * acc_t'(right));
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Enable-gated shift delay line: o_data is the sample accepted DEPTH enables ago.
module line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int W     = DATA_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (i_en) begin
      mem[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign o_data = mem[DEPTH-1];

endmodule

// File: rtl/conv3x3_sobel_stream.sv
// Streaming 3x3 Sobel-Y magnitude over a raster pixel stream; two line buffers supply the rows above.
module conv3x3_sobel_stream
  import conv_pkg::*;
#(
  parameter int ROW_LENGTH = 640
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic [DATA_W-1:0] o_data
);

  localparam int COL_W = (ROW_LENGTH > 1) ? $clog2(ROW_LENGTH) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LENGTH - 1);

  logic [DATA_W-1:0] row1_tap;
  logic [DATA_W-1:0] row2_tap;

  // Only the top and bottom window rows carry non-zero weights, so the middle row needs no taps.
  pixel_t top_l, top_m;
  pixel_t bot_l, bot_m;

  logic [COL_W-1:0] col;
  logic [1:0]       row;

  acc_t sum;
  acc_t mag;
  logic win_ok;

  line_buffer #(.DEPTH(ROW_LENGTH), .W(DATA_W)) u_lb_row1 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_valid),
    .i_data (i_data),
    .o_data (row1_tap)
  );

  line_buffer #(.DEPTH(ROW_LENGTH), .W(DATA_W)) u_lb_row2 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_valid),
    .i_data (row1_tap),
    .o_data (row2_tap)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      top_l <= '0;
      top_m <= '0;
      bot_l <= '0;
      bot_m <= '0;
    end else if (i_valid) begin
      bot_m <= pixel_t'(i_data);
      bot_l <= bot_m;
      top_m <= pixel_t'(row2_tap);
      top_l <= top_m;
    end
  end

  // Row saturates at 2: beyond that only "full window available vertically" matters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col <= '0;
      row <= '0;
    end else if (i_valid) begin
      if (col == COL_LAST) begin
        col <= '0;
        if (row != 2'd2) row <= row + 2'd1;
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  always_comb begin
    sum    = row_sum(bot_l, bot_m, pixel_t'(i_data)) - row_sum(top_l, top_m, pixel_t'(row2_tap));
    mag    = sum[ACC_W-1] ? -sum : sum;
    win_ok = (row == 2'd2) && (col >= COL_W'(2));
  end

  // Left taps at col 0/1 belong to the previous row, so those outputs are forced to zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data <= '0;
    end else if (i_valid) begin
      o_data <= win_ok ? mag[DATA_W-1:0] : '0;
    end
  end

endmodule

// File: tb/tb_conv3x3_sobel_stream.sv
// Directed bench for conv3x3_sobel_stream with an image-indexed reference model and per-cycle compare.
module tb_conv3x3_sobel_stream;

  localparam int N = 4;
  localparam int W = 12;

  // Clock/reset
  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         valid = 1'b0;
  logic [W-1:0] data  = '0;
  logic [W-1:0] o_data;

  always #5 clk = ~clk;

  conv3x3_sobel_stream #(.ROW_LENGTH(N)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_data  (data),
    .i_valid (valid),
    .o_data  (o_data)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] out_log[$];
  int           hist[$];
  logic [W-1:0] held = '0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: pixel (r,c) of the stream since reset is hist[r*N+c]; gradient from image rows.
  always @(posedge clk or posedge rst) begin : model
    int k, r, c, s, a;
    if (rst) begin
      hist.delete();
      exp_q.delete();
    end else if (valid) begin
      hist.push_back($signed(data));
      k = hist.size() - 1;
      r = k / N;
      c = k % N;
      if (r >= 2 && c >= 2) begin
        s = 0;
        for (int dc = 0; dc < 3; dc++) begin
          s += ((dc == 1) ? 2 : 1) * (hist[r*N + c-2+dc] - hist[(r-2)*N + c-2+dc]);
        end
        a = (s < 0) ? -s : s;
        exp_q.push_back(W'(a));
      end else begin
        exp_q.push_back('0);
      end
    end
  end

  // Scoreboard: every negedge o_data must equal the latest expected output (or 0 in reset).
  always @(negedge clk) begin
    if (rst) begin
      held = '0;
      check("reset", o_data, '0);
    end else if (exp_q.size() > 0) begin
      held = exp_q.pop_front();
      check("pixel", o_data, held);
      out_log.push_back(o_data);
    end else begin
      check("hold", o_data, held);
    end
  end

  // Driver tasks (called right after a negedge)
  task automatic send(input int v);
    data  = W'(v);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    out_log.delete();
  endtask

  task automatic run_img(input int img[16], input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      send(img[i]);
      if (gaps) idle($urandom_range(1, 3));
    end
    idle(2);
  endtask

  // Hand-computed literal expectations, indexed by raster position.
  task automatic check_log(input string name, input int exp_v[16], input int n);
    checks++;
    if (out_log.size() != n) begin
      errors++;
      $display("FAIL %s_count: got %0d outputs expected %0d", name, out_log.size(), n);
    end else begin
      for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", name, i), out_log[i], W'(exp_v[i]));
    end
  endtask

  int ramp[16], desc[16], step_max[16], step_neg[16];
  int ramp_exp[16]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32, 32, 0, 0, 32, 32};
  int max_exp[16]   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4092, 4092, 0, 0, 0, 0};
  int neg_exp[16]   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 4, 0, 0, 0, 0};
  int zero_exp[16]  = '{default: 0};

  initial begin
    for (int i = 0; i < 16; i++) begin
      ramp[i]     = i;
      desc[i]     = 15 - i;
      step_max[i] = (i >= 8) ? 2047 : 0;
      step_neg[i] = (i >= 8) ? 12'hFFF : 0;
    end

    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    out_log.delete();

    run_img(ramp, 16, 1'b0);
    check_log("ramp", ramp_exp, 16);

    do_reset();
    run_img(desc, 16, 1'b0);
    check_log("desc", ramp_exp, 16);

    do_reset();
    run_img(step_max, 12, 1'b0);
    check_log("max", max_exp, 12);

    do_reset();
    run_img(step_neg, 12, 1'b0);
    check_log("neg", neg_exp, 12);

    do_reset();
    run_img(ramp, 16, 1'b1);
    check_log("gaps", ramp_exp, 16);

    do_reset();
    run_img(ramp, 10, 1'b0);
    check_log("pre_rst", zero_exp, 10);
    do_reset();
    run_img(ramp, 16, 1'b0);
    check_log("post_rst", ramp_exp, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
